// File: rtl/item_mux_pkg.sv
// item_mux_pkg: shared defaults and FSM state encoding for item_mux_scan
package item_mux_pkg;
    localparam int WIDTH_DEF = 63;
    localparam int N_DEF = 12;
    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_HOLD = 2'd1;
    localparam logic [1:0] ST_SCAN = 2'd2;
    typedef enum logic [1:0] {IDLE = ST_IDLE, HOLD = ST_HOLD, SCAN = ST_SCAN} state_e;
endpackage

// File: rtl/item_mux_scan_ctr.sv
// item_mux_scan_ctr: dwell counter with a wrapping record index for scan mode
module item_mux_scan_ctr
    import item_mux_pkg::*;
#(
    parameter int N = N_DEF,
    parameter int SEL_W = 4,
    parameter int DWELL = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clear,
    input  logic             enable,
    output logic [SEL_W-1:0] idx,
    output logic             step
);
    localparam int CW = DWELL > 1 ? $clog2(DWELL) : 1;
    logic [CW-1:0] cnt;
    assign step = enable && cnt == CW'(DWELL - 1);
    // count dwell cycles on the current index; advance and wrap when the dwell expires
    always_ff @(posedge clk) begin
        if (!rst_n || clear) begin
            cnt <= '0;
            idx <= '0;
        end else if (enable) begin
            cnt <= step ? '0 : cnt + 1'b1;
            if (step) idx <= idx == SEL_W'(N - 1) ? '0 : idx + 1'b1;
        end
    end
endmodule

// File: rtl/item_mux_scan.sv
// item_mux_scan: registered record selector with hold handshake and timed scan mode
module item_mux_scan
    import item_mux_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF,
    parameter int N = N_DEF,
    parameter int SEL_W = 4,
    parameter int DWELL = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [N*WIDTH-1:0] in_flat,
    input  logic [SEL_W-1:0]   sel,
    input  logic               sel_valid,
    input  logic               scan_en,
    input  logic               out_ready,
    output logic [WIDTH-1:0]   out_data,
    output logic [SEL_W-1:0]   out_idx,
    output logic               out_valid,
    output logic               sel_err
);
    localparam int EW = (2 ** SEL_W) * WIDTH;
    localparam logic [SEL_W:0] NL = (SEL_W + 1)'(N);
    state_e state, nst;
    logic [EW-1:0] ext;
    logic [SEL_W-1:0] ctr_idx, nxt, rd_idx;
    logic [WIDTH-1:0] rec;
    logic step, sel_ok, sel_bad, take, ctr_clr;
    assign ext = EW'(in_flat);
    assign sel_ok = sel_valid && {1'b0, sel} < NL;
    assign sel_bad = sel_valid && !sel_ok;
    assign take = sel_ok && (state != HOLD || out_ready);
    assign nxt = step ? (ctr_idx == SEL_W'(N - 1) ? '0 : ctr_idx + 1'b1) : ctr_idx;
    assign rd_idx = sel_ok ? sel : state == SCAN ? nxt : '0;
    assign rec = ext[32'(rd_idx) * WIDTH +: WIDTH];
    assign ctr_clr = state != SCAN || nst != SCAN;
    // next state: a valid request wins, HOLD waits for out_ready, scan runs while scan_en is high
    always_comb begin
        nst = take ? HOLD :
              state == IDLE ? (scan_en ? SCAN : IDLE) :
              state == HOLD ? (out_ready ? IDLE : HOLD) :
              (scan_en ? SCAN : IDLE);
    end
    item_mux_scan_ctr #(.N(N), .SEL_W(SEL_W), .DWELL(DWELL)) u_ctr (
        .clk(clk),
        .rst_n(rst_n),
        .clear(ctr_clr),
        .enable(state == SCAN),
        .idx(ctr_idx),
        .step(step)
    );
    // output registers: cleared in IDLE, frozen in HOLD, reloaded on a new request or every scan cycle
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
            out_data <= '0;
            out_idx <= '0;
            out_valid <= 1'b0;
            sel_err <= 1'b0;
        end else begin
            state <= nst;
            out_valid <= nst != IDLE;
            sel_err <= sel_bad;
            if (nst == IDLE) begin
                out_data <= '0;
                out_idx <= '0;
            end else if (take || nst == SCAN) begin
                out_data <= rec;
                out_idx <= rd_idx;
            end
        end
    end
endmodule

// File: tb/tb_item_mux_scan.sv
// tb_item_mux_scan: directed and random checks of item_mux_scan against a behavioural model
module tb_item_mux_scan;
    localparam int W = 63;
    localparam int NN = 12;
    localparam int DW = 4;
    logic clk = 0;
    logic rst_n = 0;
    logic [NN*W-1:0] in_flat = '0;
    logic [3:0] sel = '0;
    logic sel_valid = 0, scan_en = 0, out_ready = 0;
    logic [W-1:0] out_data;
    logic [3:0] out_idx;
    logic out_valid, sel_err;
    logic [23:0] in2 = 24'h332211;
    logic [1:0] sel2 = '0;
    logic sel_valid2 = 0, scan_en2 = 0, out_ready2 = 0;
    logic [7:0] out_data2;
    logic [1:0] out_idx2;
    logic out_valid2, sel_err2;
    int total = 0, bad = 0;
    int m_mode = 0, m_t = 0, m_idx = 0;
    logic [W-1:0] m_data = '0;
    logic m_err = 0;

    always #5 clk = ~clk;

    item_mux_scan #(.WIDTH(W), .N(NN), .SEL_W(4), .DWELL(DW)) dut (
        .clk(clk), .rst_n(rst_n), .in_flat(in_flat), .sel(sel), .sel_valid(sel_valid),
        .scan_en(scan_en), .out_ready(out_ready), .out_data(out_data), .out_idx(out_idx),
        .out_valid(out_valid), .sel_err(sel_err)
    );

    item_mux_scan #(.WIDTH(8), .N(3), .SEL_W(2), .DWELL(1)) dut2 (
        .clk(clk), .rst_n(rst_n), .in_flat(in2), .sel(sel2), .sel_valid(sel_valid2),
        .scan_en(scan_en2), .out_ready(out_ready2), .out_data(out_data2), .out_idx(out_idx2),
        .out_valid(out_valid2), .sel_err(sel_err2)
    );

    function automatic logic [W-1:0] rec(int k);
        return in_flat[k*W +: W];
    endfunction

    // reference: mode 0 idle, 1 hold, 2 scan; scan index derived from elapsed scan time
    always @(posedge clk) begin : model
        int md, t, ix;
        logic [W-1:0] d;
        logic e;
        bit ok;
        md = m_mode; t = m_t; ix = m_idx; d = m_data; e = 0;
        if (!rst_n) begin
            md = 0; ix = 0; d = '0; t = 0;
        end else begin
            ok = sel_valid && int'(sel) < NN;
            e = sel_valid && !ok;
            if (ok && (md != 1 || out_ready)) begin
                md = 1; ix = int'(sel); d = rec(ix);
            end else if (md != 1 && scan_en) begin
                t = (md == 2) ? t + 1 : 0;
                md = 2; ix = (t / DW) % NN; d = rec(ix);
            end else if (md == 2 || out_ready) begin
                md = 0; ix = 0; d = '0;
            end
        end
        m_mode <= md; m_t <= t; m_idx <= ix; m_data <= d; m_err <= e;
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
        chk("data", 64'(out_data), 64'(m_data));
        chk("idx", 64'(out_idx), 64'(m_idx));
        chk("valid", 64'(out_valid), 64'(m_mode != 0));
        chk("err", 64'(sel_err), 64'(m_err));
    endtask

    task automatic new_rec(input int k);
        logic [63:0] r;
        r = {$urandom(), $urandom()};
        in_flat[k*W +: W] = r[W-1:0];
    endtask

    initial begin
        for (int k = 0; k < NN; k++) new_rec(k);
        @(negedge clk);
        tick();
        tick();
        chk("rst_valid", 64'(out_valid), 64'd0);
        chk("rst_data", 64'(out_data), 64'd0);
        chk("rst_valid2", 64'(out_valid2), 64'd0);
        rst_n = 1;
        sel = 4'd5; sel_valid = 1;
        tick();
        sel_valid = 0;
        chk("hold_idx5", 64'(out_idx), 64'd5);
        chk("hold_valid", 64'(out_valid), 64'd1);
        for (int i = 0; i < 10; i++) begin
            tick();
            chk("hold_stable", 64'(out_data), 64'(rec(5)));
        end
        out_ready = 1;
        tick();
        out_ready = 0;
        chk("release_data", 64'(out_data), 64'd0);
        chk("release_valid", 64'(out_valid), 64'd0);
        sel = 4'd12; sel_valid = 1;
        tick();
        chk("err12", 64'(sel_err), 64'd1);
        chk("err12_valid", 64'(out_valid), 64'd0);
        sel_valid = 0;
        tick();
        chk("err12_pulse", 64'(sel_err), 64'd0);
        sel = 4'd15; sel_valid = 1;
        tick();
        chk("err15", 64'(sel_err), 64'd1);
        sel_valid = 0;
        tick();
        chk("err15_pulse", 64'(sel_err), 64'd0);
        sel = 4'd3; sel_valid = 1;
        tick();
        chk("b2b_first", 64'(out_idx), 64'd3);
        sel = 4'd11; out_ready = 1;
        tick();
        chk("b2b_idx", 64'(out_idx), 64'd11);
        chk("b2b_valid", 64'(out_valid), 64'd1);
        sel = 4'd7; out_ready = 0;
        tick();
        chk("no_overwrite", 64'(out_idx), 64'd11);
        chk("no_err", 64'(sel_err), 64'd0);
        sel_valid = 0; out_ready = 1;
        tick();
        out_ready = 0; scan_en = 1;
        for (int c = 1; c <= 60; c++) begin
            if (c % 7 == 0) new_rec((c / 7) % NN);
            tick();
            chk("scan_seq", 64'(out_idx), 64'(((c - 1) / DW) % NN));
        end
        scan_en = 0;
        tick();
        chk("scan_stop", 64'(out_valid), 64'd0);
        scan_en = 1;
        for (int c = 0; c < 29; c++) tick();
        chk("scan_at7", 64'(out_idx), 64'd7);
        rst_n = 0;
        tick();
        chk("midscan_rst_valid", 64'(out_valid), 64'd0);
        chk("midscan_rst_data", 64'(out_data), 64'd0);
        rst_n = 1;
        tick();
        chk("resume0", 64'(out_idx), 64'd0);
        chk("resume_valid", 64'(out_valid), 64'd1);
        for (int c = 0; c < 400; c++) begin
            sel_valid = $urandom_range(0, 3) == 0;
            sel = 4'($urandom_range(0, 15));
            scan_en = $urandom_range(0, 5) != 0;
            out_ready = $urandom_range(0, 2) == 0;
            rst_n = $urandom_range(0, 80) != 0;
            if ($urandom_range(0, 3) == 0) new_rec($urandom_range(0, NN - 1));
            tick();
        end
        rst_n = 1; sel_valid = 0; scan_en = 0; out_ready = 0;
        tick();
        tick();
        scan_en2 = 1;
        for (int c = 0; c < 4; c++) begin
            tick();
            chk("d1_idx", 64'(out_idx2), 64'(c % 3));
            chk("d1_data", 64'(out_data2), 64'(in2[(c % 3)*8 +: 8]));
        end
        sel2 = 2'd2; sel_valid2 = 1;
        tick();
        sel_valid2 = 0;
        tick();
        chk("d1_hold_idx", 64'(out_idx2), 64'd2);
        chk("d1_hold_data", 64'(out_data2), 64'h33);
        chk("d1_hold_valid", 64'(out_valid2), 64'd1);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
